nand_wr: RTL and testbench
==========================

# nand_wr

Write-cycle strobe generator for the raw NAND bridge. It is the write-direction counterpart of the bridge's read strobe generator. Each accepted request produces one NAND latch cycle: a command, address or data byte driven on DQ with CLE/ALE qualified, a timed WEn low pulse and a timed hold. Completion is reported with a one-cycle Over pulse. It sits between the bridge sequencer and the NAND pad ring.

## Interface
- tSETUP_cnt, 1: cycles CLE/ALE/DQ are valid before WEn falls (tCLS/tALS/tDS); 0 treated as 1
- tWP_cnt, 2: cycles WEn held low (tWP); 0 treated as 1
- tWH_cnt, 2: cycles WEn held high with DQ/CLE/ALE still driven (tWH/tDH/tCLH); 0 treated as 1
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- Start  in  1  request strobe; sampled only in IDLE
- Type  in  2  00 command, 01 address, 10 data, 11 reserved
- Din  in  8  byte to write; captured when Start is accepted
- Busy  out  1  high whenever state ≠ IDLE
- Over  out  1  one-cycle completion pulse
- CLE  out  1  command latch enable
- ALE  out  1  address latch enable
- WEn  out  1  write enable, active low
- DQ_O  out  8  NAND data bus output
- DQ_OE  out  1  pad output enable for DQ

## Operation
- States: IDLE, SETUP, WE_LOW, WE_HIGH, OVER.
- IDLE to SETUP on Start=1 with Type≠11. Start with Type=11 is ignored and the block stays in IDLE. Din and Type are latched at acceptance.
- SETUP lasts tSETUP_cnt cycles, then goes to WE_LOW.
- WE_LOW lasts tWP_cnt cycles, then goes to WE_HIGH.
- WE_HIGH lasts tWH_cnt cycles, then goes to OVER.
- OVER lasts 1 cycle, then goes to IDLE.
- Duration counter: 8-bit, loaded on state entry, advanced every cycle. Parameters are clamped to a minimum of 1.
- Outputs are registered and computed from next-state, so they change on the same edge as the state.
  - CLE = (Type=00) in SETUP, WE_LOW and WE_HIGH.
  - ALE = (Type=01) in the same three states.
  - WEn = 0 only in WE_LOW.
  - DQ_OE = 1 and DQ_O = latched byte in SETUP, WE_LOW and WE_HIGH.
  - Over = 1 only in OVER.
- Outside the active states: DQ_O holds its last value, DQ_OE=0 and CLE=ALE=0.
- Reset values: state IDLE, WEn=1, CLE=0, ALE=0, DQ_OE=0, DQ_O=0, Over=0, Busy=0, counter=0.
- Reset mid-operation: at the next edge with RST=1, all outputs take their reset values. WEn returns high immediately and no Over is emitted.
- Start while Busy is ignored and not queued.

## Timing
- Start accepted at edge E0 puts SETUP in effect from E0.
- With defaults:
  - WEn low for cycles E0+1 and E0+2.
  - WEn high with DQ held for E0+3 and E0+4.
  - Over high for cycle E0+5.
  - IDLE from E0+6.
  - The next Start can be accepted at E0+7.
- General latency from acceptance to Over: tSETUP_cnt+tWP_cnt+tWH_cnt cycles. Request-to-request period: that value + 2.
- DQ_O is stable from SETUP entry to WE_HIGH exit. No output glitches, because every output comes from a register.

## Configuration
- NAND_WR_BURST_EN defined: adds ports Len (in, 8 bits, byte count − 1, latched at Start) and Data_Req (out, 1 bit).
  - For Type=10 with byte index i < Len, the last WE_HIGH cycle transitions to WE_LOW for the next byte, skipping SETUP.
  - Data_Req is high during that last WE_HIGH cycle. Din is captured at the edge that ends it.
  - Over pulses once, after the final byte.
  - Len is ignored for command and address cycles.
- NAND_WR_BURST_EN undefined: Len and Data_Req do not exist; every request writes exactly one byte.

## Structure
- Shared package nand_pkg holds:
  - Type encodings (NAND_CMD, NAND_ADDR, NAND_DATA)
  - State encodings shared with the read strobe generator
  - Default timing counts
- One sub-module, nand_wr_timer: loadable 8-bit cycle counter with a done flag. It is instantiated once and reloaded on every state entry.

## Test plan
- Reset, then Start with Type=00, Din=0x70 -> CLE=1, DQ_O=0x70, DQ_OE=1 from E0; WEn=0 at E0+1..E0+2; Over at E0+5; ALE stays 0.
- Type=01, Din=0x00, tSETUP_cnt=2, tWP_cnt=3, tWH_cnt=1 -> ALE=1, WEn low 3 cycles starting E0+2, Over at E0+6.
- Start held high continuously with Type=10 -> requests accepted every 7 cycles with defaults; no Start accepted while Busy=1.
- Type=11 with Start=1 -> stays IDLE; Busy=0; WEn=1; no Over.
- RST=1 asserted during WE_LOW -> at the next edge WEn=1, DQ_OE=0, CLE=0, Busy=0; no Over pulse follows.
- (NAND_WR_BURST_EN) Type=10, Len=2, bytes 0xA1/0xB2/0xC3 supplied on Data_Req -> three WEn pulses with DQ_O=0xA1, 0xB2, 0xC3; Data_Req pulses twice; a single Over.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared NAND bridge definitions: latch-cycle types, strobe FSM states,
// default timing counts and the duration-counter load helper.
package nand_pkg;

    localparam int unsigned NAND_DQ_W  = 8;
    localparam int unsigned NAND_CNT_W = 8;

    localparam int unsigned NAND_T_SETUP_DEF = 1;
    localparam int unsigned NAND_T_WP_DEF    = 2;
    localparam int unsigned NAND_T_WH_DEF    = 2;

    typedef enum logic [1:0] {
        NAND_CMD  = 2'b00,
        NAND_ADDR = 2'b01,
        NAND_DATA = 2'b10,
        NAND_RSVD = 2'b11
    } nand_type_t;

    // Write strobe uses IDLE..OVER; RE_* belong to the read strobe generator.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WE_LOW  = 3'd2,
        WE_HIGH = 3'd3,
        OVER    = 3'd4,
        RE_LOW  = 3'd5,
        RE_HIGH = 3'd6
    } nand_state_t;

    typedef struct packed {
        nand_type_t           kind;
        logic [NAND_DQ_W-1:0] data;
    } nand_req_t;

    // Counter load value for an n-cycle state; 0 behaves like 1.
    function automatic logic [NAND_CNT_W-1:0] cnt_load(input int unsigned n);
        return (n <= 1) ? '0 : NAND_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/nand_wr_if.sv
// Sequencer/pad-side signal bundle of the NAND write strobe generator.
// Len and Data_Req exist only when NAND_WR_BURST_EN is defined.
interface nand_wr_if;
    import nand_pkg::*;

    logic                 Start;
    logic [1:0]           Type;
    logic [NAND_DQ_W-1:0] Din;
`ifdef NAND_WR_BURST_EN
    logic [7:0]           Len;
    logic                 Data_Req;
`endif
    logic                 Busy;
    logic                 Over;
    logic                 CLE;
    logic                 ALE;
    logic                 WEn;
    logic [NAND_DQ_W-1:0] DQ_O;
    logic                 DQ_OE;

    modport master (
        output Start, Type, Din,
`ifdef NAND_WR_BURST_EN
        output Len,
        input  Data_Req,
`endif
        input  Busy, Over, CLE, ALE, WEn, DQ_O, DQ_OE
    );

    modport slave (
        input  Start, Type, Din,
`ifdef NAND_WR_BURST_EN
        input  Len,
        output Data_Req,
`endif
        output Busy, Over, CLE, ALE, WEn, DQ_O, DQ_OE
    );

endinterface

// File: rtl/nand_wr_timer.sv
// Loadable down-counter timing each strobe state; done_c marks the last
// cycle of the state. last_c (burst builds) flags the cycle before that.
module nand_wr_timer
    import nand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [NAND_CNT_W-1:0] load_val,
`ifdef NAND_WR_BURST_EN
    output logic                  last_c,
`endif
    output logic                  done_c
);

    logic [NAND_CNT_W-1:0] count;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - NAND_CNT_W'(1);
        end
    end

    assign done_c = (count == '0);
`ifdef NAND_WR_BURST_EN
    assign last_c = (count == NAND_CNT_W'(1));
`endif

endmodule

// File: rtl/nand_wr.sv
// NAND write-cycle strobe generator: one CLE/ALE-qualified latch cycle per
// accepted request with timed setup, WEn low pulse and hold, then Over.
// Optional multi-byte data bursts are enabled by defining NAND_WR_BURST_EN.
module nand_wr
    import nand_pkg::*;
#(
    parameter int unsigned tSETUP_cnt = NAND_T_SETUP_DEF,
    parameter int unsigned tWP_cnt    = NAND_T_WP_DEF,
    parameter int unsigned tWH_cnt    = NAND_T_WH_DEF
) (
    input  logic      CLK,
    input  logic      RST,
    nand_wr_if.slave  bus
);

    localparam logic [NAND_CNT_W-1:0] SETUP_LD = cnt_load(tSETUP_cnt);
    localparam logic [NAND_CNT_W-1:0] WP_LD    = cnt_load(tWP_cnt);
    localparam logic [NAND_CNT_W-1:0] WH_LD    = cnt_load(tWH_cnt);

    nand_state_t           state;
    nand_state_t           state_next;
    nand_req_t             req_q;
    nand_req_t             req_d;
    logic                  load_c;
    logic [NAND_CNT_W-1:0] load_val_c;
    logic                  tmr_done_c;
    logic                  active_c;

    logic                  busy_d, over_d, cle_d, ale_d, wen_d, dq_oe_d;
    logic [NAND_DQ_W-1:0]  dq_o_d;
    logic                  busy_q, over_q, cle_q, ale_q, wen_q, dq_oe_q;
    logic [NAND_DQ_W-1:0]  dq_o_q;

`ifdef NAND_WR_BURST_EN
    logic [7:0]            idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic                  more_c, more_next_c, last_next_c, tmr_last_c;
    logic                  data_req_d, data_req_q;
`endif

    nand_wr_timer u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (load_c),
        .load_val (load_val_c),
`ifdef NAND_WR_BURST_EN
        .last_c   (tmr_last_c),
`endif
        .done_c   (tmr_done_c)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request capture, timer reload and next-cycle outputs.
    always_comb begin
        state_next = state;
        req_d      = req_q;
        load_c     = 1'b0;
        load_val_c = '0;
`ifdef NAND_WR_BURST_EN
        idx_d      = idx_q;
        len_d      = len_q;
        more_c     = (req_q.kind == NAND_DATA) && (idx_q < len_q);
`endif

        case (state)
            IDLE: begin
                if (bus.Start && (nand_type_t'(bus.Type) != NAND_RSVD)) begin
                    state_next = SETUP;
                    req_d.kind = nand_type_t'(bus.Type);
                    req_d.data = bus.Din;
`ifdef NAND_WR_BURST_EN
                    idx_d      = '0;
                    len_d      = bus.Len;
`endif
                end
            end
            SETUP: begin
                if (tmr_done_c) state_next = WE_LOW;
            end
            WE_LOW: begin
                if (tmr_done_c) state_next = WE_HIGH;
            end
            WE_HIGH: begin
                if (tmr_done_c) begin
`ifdef NAND_WR_BURST_EN
                    if (more_c) begin
                        state_next = WE_LOW;
                        req_d.data = bus.Din;
                        idx_d      = 8'(idx_q + 8'd1);
                    end else
`endif
                    state_next = OVER;
                end
            end
            OVER:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Every transition is a state entry and restarts the duration count.
        load_c = (state_next != state);
        case (state_next)
            SETUP:   load_val_c = SETUP_LD;
            WE_LOW:  load_val_c = WP_LD;
            WE_HIGH: load_val_c = WH_LD;
            default: load_val_c = '0;
        endcase

        active_c = (state_next == SETUP) || (state_next == WE_LOW) ||
                   (state_next == WE_HIGH);
        busy_d   = (state_next != IDLE);
        over_d   = (state_next == OVER);
        wen_d    = (state_next != WE_LOW);
        cle_d    = active_c && (req_d.kind == NAND_CMD);
        ale_d    = active_c && (req_d.kind == NAND_ADDR);
        dq_oe_d  = active_c;
        dq_o_d   = active_c ? req_d.data : dq_o_q;

`ifdef NAND_WR_BURST_EN
        // Request the next byte during the final WE_HIGH cycle of a burst.
        more_next_c = (req_d.kind == NAND_DATA) && (idx_d < len_d);
        last_next_c = (state != WE_HIGH) ? (WH_LD == '0) : tmr_last_c;
        data_req_d  = (state_next == WE_HIGH) && last_next_c && more_next_c;
`endif
    end

    // Request latch and registered pad/status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q   <= '0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            cle_q   <= 1'b0;
            ale_q   <= 1'b0;
            wen_q   <= 1'b1;
            dq_oe_q <= 1'b0;
            dq_o_q  <= '0;
`ifdef NAND_WR_BURST_EN
            idx_q      <= '0;
            len_q      <= '0;
            data_req_q <= 1'b0;
`endif
        end else begin
            req_q   <= req_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
            cle_q   <= cle_d;
            ale_q   <= ale_d;
            wen_q   <= wen_d;
            dq_oe_q <= dq_oe_d;
            dq_o_q  <= dq_o_d;
`ifdef NAND_WR_BURST_EN
            idx_q      <= idx_d;
            len_q      <= len_d;
            data_req_q <= data_req_d;
`endif
        end
    end

    assign bus.Busy  = busy_q;
    assign bus.Over  = over_q;
    assign bus.CLE   = cle_q;
    assign bus.ALE   = ale_q;
    assign bus.WEn   = wen_q;
    assign bus.DQ_OE = dq_oe_q;
    assign bus.DQ_O  = dq_o_q;
`ifdef NAND_WR_BURST_EN
    assign bus.Data_Req = data_req_q;
`endif

endmodule

// File: tb/tb_nand_wr.sv
// Bench for nand_wr: default-timing instance (a) and a 2/3/1 instance (b).
// Stimulus pushes expected latch cycles; a negedge monitor pops on Over.
// Burst scenario is included when NAND_WR_BURST_EN is defined.
module tb_nand_wr;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    nand_wr_if bus_a ();
    nand_wr_if bus_b ();

    nand_wr dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    nand_wr #(
        .tSETUP_cnt (2),
        .tWP_cnt    (3),
        .tWH_cnt    (1)
    ) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    typedef struct packed {
        logic       busy;
        logic       over;
        logic       cle;
        logic       ale;
        logic       wen;
        logic [7:0] dq;
        logic       dq_oe;
    } obs_t;

    typedef struct {
        logic [7:0] dq;
        logic       cle;
        logic       ale;
        int         wfirst;
        int         wcnt;
        int         over_at;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   burst_mode = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];
    obs_t obs0, obs1;

    bit         in_txn [2];
    int         idx    [2];
    int         wfirst [2];
    int         wcnt   [2];
    logic [7:0] dq0    [2];
    logic       cle0   [2];
    logic       ale0   [2];
    bit         bad    [2];

    assign obs0 = {bus_a.Busy, bus_a.Over, bus_a.CLE, bus_a.ALE, bus_a.WEn, bus_a.DQ_O, bus_a.DQ_OE};
    assign obs1 = {bus_b.Busy, bus_b.Over, bus_b.CLE, bus_b.ALE, bus_b.WEn, bus_b.DQ_O, bus_b.DQ_OE};

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t mk(input logic [7:0] dq, input logic cle, input logic ale,
                                input int wf, input int wc, input int ov);
        exp_t e;
        e.dq = dq; e.cle = cle; e.ale = ale; e.wfirst = wf; e.wcnt = wc; e.over_at = ov;
        return e;
    endfunction

    // Monitor: track each busy window, compare against the queued expectation at Over.
    always @(negedge CLK) begin
        for (int b = 0; b < 2; b++) begin
            obs_t o;
            exp_t e;
            bit   have;
            o = (b == 0) ? obs0 : obs1;
            if (RST || (burst_mode && b == 0)) begin
                in_txn[b] = 1'b0;
            end else begin
                if (o.busy && !in_txn[b]) begin
                    in_txn[b] = 1'b1;
                    idx[b]    = 0;
                    wfirst[b] = -1;
                    wcnt[b]   = 0;
                    dq0[b]    = o.dq;
                    cle0[b]   = o.cle;
                    ale0[b]   = o.ale;
                    bad[b]    = 1'b0;
                end
                if (in_txn[b]) begin
                    if (!o.over && (!o.dq_oe || o.dq != dq0[b] || o.cle != cle0[b] || o.ale != ale0[b]))
                        bad[b] = 1'b1;
                    if (!o.wen) begin
                        if (wfirst[b] < 0) wfirst[b] = idx[b];
                        wcnt[b]++;
                    end
                    if (o.over) begin
                        have = 1'b0;
                        if (b == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (b == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            checks++;
                            errors++;
                            $display("FAIL mon%0d_over: got an Over pulse expected none (queue empty)", b);
                        end else begin
                            chk($sformatf("mon%0d_dq", b), int'(dq0[b]), int'(e.dq));
                            chk($sformatf("mon%0d_cle", b), int'(cle0[b]), int'(e.cle));
                            chk($sformatf("mon%0d_ale", b), int'(ale0[b]), int'(e.ale));
                            chk($sformatf("mon%0d_wen_first", b), wfirst[b], e.wfirst);
                            chk($sformatf("mon%0d_wen_len", b), wcnt[b], e.wcnt);
                            chk($sformatf("mon%0d_over_at", b), idx[b], e.over_at);
                            chk($sformatf("mon%0d_bus_stable", b), int'(bad[b]), 0);
                        end
                        in_txn[b] = 1'b0;
                    end else if (!o.busy) begin
                        checks++;
                        errors++;
                        $display("FAIL mon%0d_no_over: got Busy low at cycle %0d expected Over first", b, idx[b]);
                        in_txn[b] = 1'b0;
                    end
                    idx[b]++;
                end
            end
        end
    end

`ifdef NAND_WR_BURST_EN
    logic [7:0] burst_bytes [3];
    logic [7:0] dq_seen [4];
`endif

    initial begin
        int accepts;
        logic prev_busy;

        RST = 1'b1;
        bus_a.Start = 1'b0; bus_a.Type = 2'b00; bus_a.Din = 8'h00;
        bus_b.Start = 1'b0; bus_b.Type = 2'b00; bus_b.Din = 8'h00;
`ifdef NAND_WR_BURST_EN
        bus_a.Len = 8'd0;
        bus_b.Len = 8'd0;
`endif
        repeat (3) tick();

        // Reset values.
        chk("rst_wen",   bus_a.WEn,   1);
        chk("rst_cle",   bus_a.CLE,   0);
        chk("rst_ale",   bus_a.ALE,   0);
        chk("rst_dq_oe", bus_a.DQ_OE, 0);
        chk("rst_dq_o",  bus_a.DQ_O,  0);
        chk("rst_over",  bus_a.Over,  0);
        chk("rst_busy",  bus_a.Busy,  0);
        RST = 1'b0;
        tick();

        // Command 0x70 with default timing.
        q0.push_back(mk(8'h70, 1'b1, 1'b0, 1, 2, 5));
        bus_a.Start = 1'b1; bus_a.Type = 2'b00; bus_a.Din = 8'h70;
        tick();                                        // E0
        bus_a.Start = 1'b0; bus_a.Din = 8'hFF;
        chk("cmd_e0_cle",   bus_a.CLE,   1);
        chk("cmd_e0_ale",   bus_a.ALE,   0);
        chk("cmd_e0_dq",    bus_a.DQ_O,  8'h70);
        chk("cmd_e0_dq_oe", bus_a.DQ_OE, 1);
        chk("cmd_e0_wen",   bus_a.WEn,   1);
        chk("cmd_e0_busy",  bus_a.Busy,  1);
        tick(); chk("cmd_e1_wen", bus_a.WEn, 0);
        tick(); chk("cmd_e2_wen", bus_a.WEn, 0);
        tick(); chk("cmd_e3_wen", bus_a.WEn, 1);
        chk("cmd_e3_dq", bus_a.DQ_O, 8'h70);
        tick(); chk("cmd_e4_dq_oe", bus_a.DQ_OE, 1);
        tick(); chk("cmd_e5_over", bus_a.Over, 1);
        chk("cmd_e5_dq_oe", bus_a.DQ_OE, 0);
        chk("cmd_e5_cle", bus_a.CLE, 0);
        tick(); chk("cmd_e6_over", bus_a.Over, 0);
        chk("cmd_e6_busy", bus_a.Busy, 0);
        chk("cmd_e6_dq_hold", bus_a.DQ_O, 8'h70);

        // Address 0x00 on the 2/3/1 instance.
        q1.push_back(mk(8'h00, 1'b0, 1'b1, 2, 3, 6));
        bus_b.Start = 1'b1; bus_b.Type = 2'b01; bus_b.Din = 8'h00;
        tick();                                        // E0
        bus_b.Start = 1'b0;
        chk("adr_e0_ale", bus_b.ALE, 1);
        chk("adr_e0_cle", bus_b.CLE, 0);
        tick(); chk("adr_e1_wen", bus_b.WEn, 1);
        tick(); chk("adr_e2_wen", bus_b.WEn, 0);
        tick(); tick(); chk("adr_e4_wen", bus_b.WEn, 0);
        tick(); chk("adr_e5_wen", bus_b.WEn, 1);
        chk("adr_e5_over", bus_b.Over, 0);
        tick(); chk("adr_e6_over", bus_b.Over, 1);
        tick(); chk("adr_e7_busy", bus_b.Busy, 0);

        // Start held high: acceptances at E0, E0+7, E0+14 only.
        repeat (3) q0.push_back(mk(8'h5A, 1'b0, 1'b0, 1, 2, 5));
        bus_a.Start = 1'b1; bus_a.Type = 2'b10; bus_a.Din = 8'h5A;
        accepts = 0;
        prev_busy = bus_a.Busy;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_a.Busy && !prev_busy) accepts++;
            prev_busy = bus_a.Busy;
            if (i == 5) chk("hold_e5_over", bus_a.Over, 1);
            if (i == 6) chk("hold_e6_busy", bus_a.Busy, 0);
            if (i == 7) chk("hold_e7_busy", bus_a.Busy, 1);
        end
        bus_a.Start = 1'b0;
        chk("hold_accepts", accepts, 3);
        repeat (7) tick();

        // Reserved type is ignored.
        bus_a.Start = 1'b1; bus_a.Type = 2'b11; bus_a.Din = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rsvd_busy_%0d", i), bus_a.Busy, 0);
            chk($sformatf("rsvd_wen_%0d", i), bus_a.WEn, 1);
            chk($sformatf("rsvd_over_%0d", i), bus_a.Over, 0);
        end
        bus_a.Start = 1'b0;
        tick();

        // Reset during WE_LOW: outputs drop at once, no Over afterwards.
        bus_a.Start = 1'b1; bus_a.Type = 2'b00; bus_a.Din = 8'h90;
        tick();                                        // E0
        bus_a.Start = 1'b0;
        tick(); chk("rst_mid_wen_low", bus_a.WEn, 0);
        RST = 1'b1;
        tick();
        chk("rst_mid_wen",   bus_a.WEn,   1);
        chk("rst_mid_dq_oe", bus_a.DQ_OE, 0);
        chk("rst_mid_cle",   bus_a.CLE,   0);
        chk("rst_mid_busy",  bus_a.Busy,  0);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rst_mid_no_over_%0d", i), bus_a.Over, 0);
        end

`ifdef NAND_WR_BURST_EN
        // Three-byte data burst fed on Data_Req.
        begin
            int   nseen, dreqs, overs, k;
            logic prev_wen;
            burst_bytes[0] = 8'hA1; burst_bytes[1] = 8'hB2; burst_bytes[2] = 8'hC3;
            burst_mode = 1'b1;
            nseen = 0; dreqs = 0; overs = 0; k = 1;
            bus_a.Start = 1'b1; bus_a.Type = 2'b10; bus_a.Din = burst_bytes[0]; bus_a.Len = 8'd2;
            tick();
            bus_a.Start = 1'b0; bus_a.Len = 8'd0;
            prev_wen = 1'b1;
            for (int i = 0; i < 30; i++) begin
                if (bus_a.Data_Req) begin
                    dreqs++;
                    if (k < 3) begin bus_a.Din = burst_bytes[k]; k++; end
                end
                if (!bus_a.WEn && prev_wen) begin
                    if (nseen < 4) dq_seen[nseen] = bus_a.DQ_O;
                    nseen++;
                end
                if (bus_a.Over) overs++;
                prev_wen = bus_a.WEn;
                tick();
            end
            chk("burst_pulses", nseen, 3);
            chk("burst_dq0", dq_seen[0], 8'hA1);
            chk("burst_dq1", dq_seen[1], 8'hB2);
            chk("burst_dq2", dq_seen[2], 8'hC3);
            chk("burst_data_req", dreqs, 2);
            chk("burst_over", overs, 1);
            chk("burst_idle", bus_a.Busy, 0);
            burst_mode = 1'b0;
            tick();
        end
`endif

        chk("q_a_drained", q0.size(), 0);
        chk("q_b_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
